// File: rtl/cpu_ahb_2m_arbiter.sv
// Two-master AHB-Lite arbiter in front of the single CPU-side AHB port.
// Optional stall counters are built when AHB_ARB_PERF_CNT_EN is defined.
module cpu_ahb_2m_arbiter #(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             i_pad_clk,
   input  logic             i_pad_rst_b,

   input  logic [AW-1:0]    m0_haddr,
   input  logic [1:0]       m0_htrans,
   input  logic             m0_hwrite,
   input  logic [2:0]       m0_hsize,
   input  logic [2:0]       m0_hburst,
   input  logic [3:0]       m0_hprot,
   input  logic [DW-1:0]    m0_hwdata,
   output logic [DW-1:0]    m0_hrdata,
   output logic             m0_hready,
   output logic             m0_hresp,

   input  logic [AW-1:0]    m1_haddr,
   input  logic [1:0]       m1_htrans,
   input  logic             m1_hwrite,
   input  logic [2:0]       m1_hsize,
   input  logic [2:0]       m1_hburst,
   input  logic [3:0]       m1_hprot,
   input  logic [DW-1:0]    m1_hwdata,
   output logic [DW-1:0]    m1_hrdata,
   output logic             m1_hready,
   output logic             m1_hresp,

   output logic [AW-1:0]    s_haddr,
   output logic [1:0]       s_htrans,
   output logic             s_hwrite,
   output logic [2:0]       s_hsize,
   output logic [2:0]       s_hburst,
   output logic [3:0]       s_hprot,
   output logic [DW-1:0]    s_hwdata,
   input  logic [DW-1:0]    s_hrdata,
   input  logic             s_hreadyout,
   input  logic             s_hresp,

   output logic             gnt,
   output logic [CNT_W-1:0] m0_stall_cnt,
   output logic [CNT_W-1:0] m1_stall_cnt
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   logic       gnt_q, gnt_d;
   logic       down_q, down_d;
   logic [1:0] own_trans;
   logic [1:0] oth_trans;
   logic       do_switch;

   // Handover only on an accepted IDLE from the owner, so bursts and pending
   // owner data phases are never split.
   always_comb begin
      own_trans = gnt_q ? m1_htrans : m0_htrans;
      oth_trans = gnt_q ? m0_htrans : m1_htrans;
      do_switch = s_hreadyout && (own_trans == TransIdle) && (oth_trans == TransNonseq);
      gnt_d     = gnt_q ^ do_switch;
      down_d    = s_hreadyout ? gnt_q : down_q;
   end

   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         gnt_q  <= 1'b0;
         down_q <= 1'b0;
      end else begin
         gnt_q  <= gnt_d;
         down_q <= down_d;
      end
   end

   assign gnt = gnt_q;

   always_comb begin
      if (gnt_q) begin
         s_haddr  = m1_haddr;
         s_htrans = m1_htrans;
         s_hwrite = m1_hwrite;
         s_hsize  = m1_hsize;
         s_hburst = m1_hburst;
         s_hprot  = m1_hprot;
      end else begin
         s_haddr  = m0_haddr;
         s_htrans = m0_htrans;
         s_hwrite = m0_hwrite;
         s_hsize  = m0_hsize;
         s_hburst = m0_hburst;
         s_hprot  = m0_hprot;
      end
      s_hwdata = down_q ? m1_hwdata : m0_hwdata;
   end

   // Non-owners see HREADY low only while they present a NONSEQ, which
   // holds that address until the grant reaches them.
   always_comb begin
      m0_hrdata = '0;
      m0_hresp  = 1'b0;
      m0_hready = (m0_htrans != TransNonseq);
      if (!down_q) begin
         m0_hrdata = s_hrdata;
         m0_hresp  = s_hresp;
         m0_hready = s_hreadyout;
      end else if (!gnt_q) begin
         m0_hready = s_hreadyout;
      end
   end

   always_comb begin
      m1_hrdata = '0;
      m1_hresp  = 1'b0;
      m1_hready = (m1_htrans != TransNonseq);
      if (down_q) begin
         m1_hrdata = s_hrdata;
         m1_hresp  = s_hresp;
         m1_hready = s_hreadyout;
      end else if (gnt_q) begin
         m1_hready = s_hreadyout;
      end
   end

`ifdef AHB_ARB_PERF_CNT_EN
   logic [CNT_W-1:0] m0_cnt_q;
   logic [CNT_W-1:0] m1_cnt_q;
   logic             m0_stall;
   logic             m1_stall;

   assign m0_stall = (m0_htrans == TransNonseq) && gnt_q;
   assign m1_stall = (m1_htrans == TransNonseq) && !gnt_q;

   // Saturating; cleared only by reset.
   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         m0_cnt_q <= '0;
         m1_cnt_q <= '0;
      end else begin
         if (m0_stall && !(&m0_cnt_q)) m0_cnt_q <= m0_cnt_q + CNT_W'(1);
         if (m1_stall && !(&m1_cnt_q)) m1_cnt_q <= m1_cnt_q + CNT_W'(1);
      end
   end

   assign m0_stall_cnt = m0_cnt_q;
   assign m1_stall_cnt = m1_cnt_q;
`else
   assign m0_stall_cnt = '0;
   assign m1_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ahb_2m_arbiter.sv
// Self-checking bench for cpu_ahb_2m_arbiter: directed scenarios plus a
// randomized run against a rule-level model of grant, data owner and stall counts.
module tb_cpu_ahb_2m_arbiter;

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] SQ = 2'b11;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR4  = 3'b011;
   localparam int unsigned CntMax = 255;
`ifdef AHB_ARB_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic clk;
   logic rst_n;

   logic [31:0] haddr  [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [2:0]  hsize  [2];
   logic [2:0]  hburst [2];
   logic [3:0]  hprot  [2];
   logic [31:0] hwdata [2];

   logic [31:0] m0_hrdata, m1_hrdata;
   logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
   logic [31:0] s_haddr, s_hwdata, s_hrdata;
   logic [1:0]  s_htrans;
   logic        s_hwrite, s_hreadyout, s_hresp, gnt;
   logic [2:0]  s_hsize, s_hburst;
   logic [3:0]  s_hprot;
   logic [7:0]  m0_stall_cnt, m1_stall_cnt;

   logic [31:0] got_rdata [2];
   logic        got_ready [2];
   logic        got_resp  [2];
   logic [7:0]  got_cnt   [2];

   int checks;
   int failures;

   cpu_ahb_2m_arbiter #(
      .AW    (32),
      .DW    (32),
      .CNT_W (8)
   ) dut (
      .i_pad_clk    (clk),
      .i_pad_rst_b  (rst_n),
      .m0_haddr     (haddr[0]),
      .m0_htrans    (htrans[0]),
      .m0_hwrite    (hwrite[0]),
      .m0_hsize     (hsize[0]),
      .m0_hburst    (hburst[0]),
      .m0_hprot     (hprot[0]),
      .m0_hwdata    (hwdata[0]),
      .m0_hrdata    (m0_hrdata),
      .m0_hready    (m0_hready),
      .m0_hresp     (m0_hresp),
      .m1_haddr     (haddr[1]),
      .m1_htrans    (htrans[1]),
      .m1_hwrite    (hwrite[1]),
      .m1_hsize     (hsize[1]),
      .m1_hburst    (hburst[1]),
      .m1_hprot     (hprot[1]),
      .m1_hwdata    (hwdata[1]),
      .m1_hrdata    (m1_hrdata),
      .m1_hready    (m1_hready),
      .m1_hresp     (m1_hresp),
      .s_haddr      (s_haddr),
      .s_htrans     (s_htrans),
      .s_hwrite     (s_hwrite),
      .s_hsize      (s_hsize),
      .s_hburst     (s_hburst),
      .s_hprot      (s_hprot),
      .s_hwdata     (s_hwdata),
      .s_hrdata     (s_hrdata),
      .s_hreadyout  (s_hreadyout),
      .s_hresp      (s_hresp),
      .gnt          (gnt),
      .m0_stall_cnt (m0_stall_cnt),
      .m1_stall_cnt (m1_stall_cnt)
   );

   assign got_rdata[0] = m0_hrdata;
   assign got_rdata[1] = m1_hrdata;
   assign got_ready[0] = m0_hready;
   assign got_ready[1] = m1_hready;
   assign got_resp[0]  = m0_hresp;
   assign got_resp[1]  = m1_hresp;
   assign got_cnt[0]   = m0_stall_cnt;
   assign got_cnt[1]   = m1_stall_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the address phase, who owns the data phase,
   // and how many cycles each master has spent waiting on a NONSEQ.
   int          mod_gnt;
   int          mod_down;
   int unsigned mod_cnt [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_gnt    <= 0;
         mod_down   <= 0;
         mod_cnt[0] <= 0;
         mod_cnt[1] <= 0;
      end else begin
         for (int x = 0; x < 2; x++)
            if (PerfEn && htrans[x] == NS && x != mod_gnt && mod_cnt[x] < CntMax)
               mod_cnt[x] <= mod_cnt[x] + 1;
         if (s_hreadyout) begin
            mod_down <= mod_gnt;
            if (htrans[mod_gnt] == ID && htrans[1 - mod_gnt] == NS) mod_gnt <= 1 - mod_gnt;
         end
      end
   end

   logic        exp_ready [2];
   logic        exp_resp  [2];
   logic [31:0] exp_rdata [2];

   always_comb begin
      for (int x = 0; x < 2; x++) begin
         exp_rdata[x] = '0;
         exp_resp[x]  = 1'b0;
         exp_ready[x] = 1'b1;
         if (x == mod_down) begin
            exp_rdata[x] = s_hrdata;
            exp_resp[x]  = s_hresp;
            exp_ready[x] = s_hreadyout;
         end else if (x == mod_gnt) begin
            exp_ready[x] = s_hreadyout;
         end else begin
            exp_ready[x] = (htrans[x] != NS);
         end
      end
   end

   task automatic drive(input int x, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] bu);
      htrans[x] = tr;
      haddr[x]  = a;
      hwrite[x] = wr;
      hburst[x] = bu;
      hsize[x]  = 3'b010;
      hprot[x]  = 4'b0011;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks += 5;
      if (gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
      if (m0_stall_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt0 got=%0d exp=0", m0_stall_cnt); end
      if (m1_stall_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt1 got=%0d exp=0", m1_stall_cnt); end
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL rst_m0_hready got=%b exp=1", m0_hready); end
      if (m1_hready !== 1'b1) begin failures++; $display("FAIL rst_m1_hready got=%b exp=1", m1_hready); end
      step;
      rst_n = 1'b1;
   endtask

   task automatic test_m0_single;
      drive(0, NS, 32'h0000_1000, 1'b0, SINGLE);
      drive(1, ID, 32'h0, 1'b0, SINGLE);
      @(negedge clk);
      checks += 3;
      if (gnt !== 1'b0) begin failures++; $display("FAIL t1_gnt got=%b exp=0", gnt); end
      if (s_haddr !== 32'h0000_1000) begin failures++; $display("FAIL t1_addr got=%h exp=00001000", s_haddr); end
      if (m1_hready !== 1'b1) begin failures++; $display("FAIL t1_m1_hready got=%b exp=1", m1_hready); end
      step;
      drive(0, ID, 32'h0, 1'b0, SINGLE);
      s_hrdata = 32'hCAFE_0001;
      @(negedge clk);
      checks += 3;
      if (m0_hrdata !== 32'hCAFE_0001) begin failures++; $display("FAIL t1_rdata got=%h exp=cafe0001", m0_hrdata); end
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL t1_m0_hready got=%b exp=1", m0_hready); end
      if (m1_hready !== 1'b1) begin failures++; $display("FAIL t1_m1_hready_dp got=%b exp=1", m1_hready); end
      step;
   endtask

   task automatic test_burst_hold;
      for (int b = 0; b < 5; b++) begin
         if (b < 4) drive(0, (b == 0) ? NS : SQ, 32'h100 + 32'(4 * b), 1'b0, INCR4);
         else drive(0, ID, 32'h110, 1'b0, INCR4);
         if (b >= 1) drive(1, NS, 32'h200, 1'b0, SINGLE);
         @(negedge clk);
         checks++;
         if (gnt !== 1'b0) begin failures++; $display("FAIL t2_gnt b=%0d got=%b exp=0", b, gnt); end
         if (b >= 1) begin
            checks++;
            if (m1_hready !== 1'b0) begin failures++; $display("FAIL t2_m1_hold b=%0d got=%b exp=0", b, m1_hready); end
         end
         step;
      end
      @(negedge clk);
      checks += 3;
      if (gnt !== 1'b1) begin failures++; $display("FAIL t2_switch got=%b exp=1", gnt); end
      if (s_haddr !== 32'h200) begin failures++; $display("FAIL t2_addr got=%h exp=00000200", s_haddr); end
      if (m1_hready !== 1'b1) begin failures++; $display("FAIL t2_m1_go got=%b exp=1", m1_hready); end
      step;
      drive(1, ID, 32'h0, 1'b0, SINGLE);
      step;
   endtask

   task automatic test_simultaneous;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive(0, (c < 3) ? NS : ID, 32'h10 + 32'(4 * c), 1'b0, SINGLE);
         drive(1, NS, 32'h400, 1'b0, SINGLE);
         @(negedge clk);
         checks += 3;
         if (gnt !== 1'b0) begin failures++; $display("FAIL t3_gnt c=%0d got=%b exp=0", c, gnt); end
         if (m1_hready !== 1'b0) begin failures++; $display("FAIL t3_m1_hold c=%0d got=%b exp=0", c, m1_hready); end
         if (s_haddr !== 32'h10 + 32'(4 * c)) begin
            failures++; $display("FAIL t3_addr c=%0d got=%h exp=%h", c, s_haddr, 32'h10 + 32'(4 * c));
         end
         step;
      end
      @(negedge clk);
      checks += 4;
      if (gnt !== 1'b1) begin failures++; $display("FAIL t3_switch got=%b exp=1", gnt); end
      if (s_haddr !== 32'h400) begin failures++; $display("FAIL t3_addr_m1 got=%h exp=00000400", s_haddr); end
      if (m1_stall_cnt !== (PerfEn ? 8'd4 : 8'd0)) begin
         failures++; $display("FAIL t3_m1_cnt got=%0d exp=%0d", m1_stall_cnt, PerfEn ? 4 : 0);
      end
      if (m0_stall_cnt !== 8'd0) begin failures++; $display("FAIL t3_m0_cnt got=%0d exp=0", m0_stall_cnt); end
      step;
      drive(1, ID, 32'h0, 1'b0, SINGLE);
      step;
   endtask

   task automatic test_wait_write;
      drive(1, NS, 32'h300, 1'b1, SINGLE);
      hwdata[1] = 32'h1111_2222;
      drive(0, ID, 32'h0, 1'b0, SINGLE);
      @(negedge clk);
      checks += 2;
      if (s_haddr !== 32'h300) begin failures++; $display("FAIL t4_addr got=%h exp=00000300", s_haddr); end
      if (s_hwrite !== 1'b1) begin failures++; $display("FAIL t4_hwrite got=%b exp=1", s_hwrite); end
      step;
      for (int c = 0; c < 4; c++) begin
         drive(1, ID, 32'h300, 1'b1, SINGLE);
         hwdata[1] = 32'hDEAD_BEEF;
         drive(0, NS, 32'h500, 1'b0, SINGLE);
         s_hreadyout = (c == 3);
         @(negedge clk);
         checks += 4;
         if (s_hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t4_wdata c=%0d got=%h exp=deadbeef", c, s_hwdata); end
         if (gnt !== 1'b1) begin failures++; $display("FAIL t4_gnt_hold c=%0d got=%b exp=1", c, gnt); end
         if (m0_hready !== 1'b0) begin failures++; $display("FAIL t4_m0_hold c=%0d got=%b exp=0", c, m0_hready); end
         if (m1_hready !== (c == 3)) begin failures++; $display("FAIL t4_m1_hready c=%0d got=%b exp=%0d", c, m1_hready, c == 3); end
         step;
      end
      @(negedge clk);
      checks += 4;
      if (gnt !== 1'b0) begin failures++; $display("FAIL t4_switch got=%b exp=0", gnt); end
      if (s_haddr !== 32'h500) begin failures++; $display("FAIL t4_addr_m0 got=%h exp=00000500", s_haddr); end
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL t4_m0_go got=%b exp=1", m0_hready); end
      if (m0_stall_cnt !== (PerfEn ? 8'd4 : 8'd0)) begin
         failures++; $display("FAIL t4_m0_cnt got=%0d exp=%0d", m0_stall_cnt, PerfEn ? 4 : 0);
      end
      step;
   endtask

   task automatic test_error;
      drive(0, NS, 32'h600, 1'b0, SINGLE);
      step;
      drive(0, ID, 32'h0, 1'b0, SINGLE);
      drive(1, NS, 32'h700, 1'b0, SINGLE);
      s_hresp = 1'b1;
      s_hreadyout = 1'b0;
      @(negedge clk);
      checks += 4;
      if (m0_hresp !== 1'b1) begin failures++; $display("FAIL t5_resp1 got=%b exp=1", m0_hresp); end
      if (m0_hready !== 1'b0) begin failures++; $display("FAIL t5_ready1 got=%b exp=0", m0_hready); end
      if (m1_hresp !== 1'b0) begin failures++; $display("FAIL t5_m1_resp1 got=%b exp=0", m1_hresp); end
      if (m1_hready !== 1'b0) begin failures++; $display("FAIL t5_m1_hold got=%b exp=0", m1_hready); end
      step;
      s_hreadyout = 1'b1;
      @(negedge clk);
      checks += 3;
      if (m0_hresp !== 1'b1) begin failures++; $display("FAIL t5_resp2 got=%b exp=1", m0_hresp); end
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL t5_ready2 got=%b exp=1", m0_hready); end
      if (m1_hresp !== 1'b0) begin failures++; $display("FAIL t5_m1_resp2 got=%b exp=0", m1_hresp); end
      step;
      s_hresp = 1'b0;
      @(negedge clk);
      checks += 2;
      if (gnt !== 1'b1) begin failures++; $display("FAIL t5_switch got=%b exp=1", gnt); end
      if (s_haddr !== 32'h700) begin failures++; $display("FAIL t5_addr got=%h exp=00000700", s_haddr); end
      step;
      drive(1, ID, 32'h0, 1'b0, SINGLE);
      step;
   endtask

   task automatic test_async_reset;
      drive(1, NS, 32'h800, 1'b1, INCR4);
      drive(0, ID, 32'h0000_0ABC, 1'b0, SINGLE);
      hwdata[0] = 32'hA5A5_0000;
      hwdata[1] = 32'h5A5A_1111;
      @(negedge clk);
      checks++;
      if (gnt !== 1'b1) begin failures++; $display("FAIL t6_pre_gnt got=%b exp=1", gnt); end
      step;
      drive(1, SQ, 32'h804, 1'b1, INCR4);
      #2;
      rst_n = 1'b0;
      #1;
      checks += 6;
      if (gnt !== 1'b0) begin failures++; $display("FAIL t6_gnt got=%b exp=0", gnt); end
      if (m0_stall_cnt !== 8'd0) begin failures++; $display("FAIL t6_cnt0 got=%0d exp=0", m0_stall_cnt); end
      if (m1_stall_cnt !== 8'd0) begin failures++; $display("FAIL t6_cnt1 got=%0d exp=0", m1_stall_cnt); end
      if (s_hwdata !== 32'hA5A5_0000) begin failures++; $display("FAIL t6_down got=%h exp=a5a50000", s_hwdata); end
      if (s_haddr !== 32'h0000_0ABC) begin failures++; $display("FAIL t6_addr got=%h exp=00000abc", s_haddr); end
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL t6_m0_hready got=%b exp=1", m0_hready); end
      drive(1, ID, 32'h0, 1'b0, SINGLE);
      s_hreadyout = 1'b0;
      step;
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (m0_hready !== 1'b0) begin failures++; $display("FAIL t6_post_lo got=%b exp=0", m0_hready); end
      if (gnt !== 1'b0) begin failures++; $display("FAIL t6_post_gnt got=%b exp=0", gnt); end
      step;
      s_hreadyout = 1'b1;
      @(negedge clk);
      checks++;
      if (m0_hready !== 1'b1) begin failures++; $display("FAIL t6_post_hi got=%b exp=1", m0_hready); end
      step;
   endtask

   task automatic test_random;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int x = 0; x < 2; x++) begin
            htrans[x] = 2'($urandom_range(0, 3));
            haddr[x]  = $urandom;
            hwrite[x] = 1'($urandom_range(0, 1));
            hsize[x]  = 3'($urandom_range(0, 7));
            hburst[x] = 3'($urandom_range(0, 7));
            hprot[x]  = 4'($urandom_range(0, 15));
            hwdata[x] = $urandom;
         end
         s_hreadyout = ($urandom_range(0, 3) != 0);
         s_hresp     = ($urandom_range(0, 7) == 0);
         s_hrdata    = $urandom;
         @(negedge clk);
         checks += 6;
         if (gnt !== 1'(mod_gnt)) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%0d", cyc, gnt, mod_gnt); end
         if (s_haddr !== haddr[mod_gnt] || s_htrans !== htrans[mod_gnt]) begin
            failures++; $display("FAIL rnd_addr cyc=%0d got=%h/%b exp=%h/%b", cyc, s_haddr, s_htrans,
                                 haddr[mod_gnt], htrans[mod_gnt]);
         end
         if (s_hwrite !== hwrite[mod_gnt] || s_hsize !== hsize[mod_gnt]) begin
            failures++; $display("FAIL rnd_ctl cyc=%0d got=%b/%h exp=%b/%h", cyc, s_hwrite, s_hsize,
                                 hwrite[mod_gnt], hsize[mod_gnt]);
         end
         if (s_hburst !== hburst[mod_gnt] || s_hprot !== hprot[mod_gnt]) begin
            failures++; $display("FAIL rnd_bp cyc=%0d got=%h/%h exp=%h/%h", cyc, s_hburst, s_hprot,
                                 hburst[mod_gnt], hprot[mod_gnt]);
         end
         if (s_hwdata !== hwdata[mod_down]) begin
            failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, s_hwdata, hwdata[mod_down]);
         end
         if (got_cnt[0] !== 8'(mod_cnt[0]) || got_cnt[1] !== 8'(mod_cnt[1])) begin
            failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, got_cnt[0], got_cnt[1],
                                 mod_cnt[0], mod_cnt[1]);
         end
         for (int x = 0; x < 2; x++) begin
            checks += 3;
            if (got_ready[x] !== exp_ready[x]) begin
               failures++; $display("FAIL rnd_hready m%0d cyc=%0d got=%b exp=%b", x, cyc, got_ready[x], exp_ready[x]);
            end
            if (got_resp[x] !== exp_resp[x]) begin
               failures++; $display("FAIL rnd_hresp m%0d cyc=%0d got=%b exp=%b", x, cyc, got_resp[x], exp_resp[x]);
            end
            if (got_rdata[x] !== exp_rdata[x]) begin
               failures++; $display("FAIL rnd_hrdata m%0d cyc=%0d got=%h exp=%h", x, cyc, got_rdata[x], exp_rdata[x]);
            end
         end
         step;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      for (int x = 0; x < 2; x++) begin
         drive(x, ID, 32'h0, 1'b0, SINGLE);
         hwdata[x] = 32'h0;
      end
      s_hrdata    = 32'h0;
      s_hreadyout = 1'b1;
      s_hresp     = 1'b0;
      test_reset;
      test_m0_single;
      test_burst_hold;
      test_simultaneous;
      test_wait_write;
      test_error;
      test_async_reset;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
